fetch_redirect_unit: RTL and testbench

- Fetch-side consumer of the branch/jump redirect (branch_flush + branch_pc) produced in the execute stage.
- Owns the architectural fetch PC and issues instruction-memory requests over a req/gnt/rvalid handshake.
- Buffers returned instructions for decode and squashes wrong-path fetches on redirect.
- Sits between instruction memory and the IF/ID boundary.

---
 rtl/fetch_redirect_unit_pkg.sv | 35 +++
 rtl/fetch_buffer.sv | 75 +++++++
 rtl/fetch_redirect_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit_pkg
// Brief    : Shared types and constants for the fetch redirect unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_redirect_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'b00,
    FETCH_REQ    = 2'b01,
    FETCH_WAIT   = 2'b10,
    FETCH_SQUASH = 2'b11
  } fetch_state_e;

  // One buffered fetch result
  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Two-entry FIFO of {pc, instr} with a registered head entry.
//            Clear has priority over push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
  import fetch_redirect_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  output logic [1:0]   o_count,
  output logic         o_head_valid,
  output fetch_entry_t o_head
);

  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;

  logic w_pop;
  logic w_push;

  // A pop of an empty buffer or a push into a full one (without a pop) is ignored
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Head/tail storage and occupancy; the head register drives decode directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_count <= 2'd0;
    end else begin
      case ({w_pop, w_push})
        2'b10: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd0) begin
            r_head <= i_push_entry;
          end else begin
            r_tail <= i_push_entry;
          end
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new entry lands behind whatever remains
          if (r_count == 2'd1) begin
            r_head <= i_push_entry;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != 2'd0);
  assign o_head       = r_head;

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit
// Brief    : Owns the fetch PC, issues instruction-memory requests over a
//            req/gnt/rvalid handshake, buffers returned instructions for
//            decode and squashes wrong-path fetches on branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2  // only 2 is supported
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_branch_flush,
  input  logic [XLEN-1:0]        i_branch_pc,
  input  logic                   i_stall,
  output logic                   o_imem_req,
  output logic [XLEN-1:0]        o_imem_addr,
  input  logic                   i_imem_gnt,
  input  logic                   i_imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic                   o_if_valid,
  output logic [XLEN-1:0]        o_if_pc,
  output logic [INSTR_WIDTH-1:0] o_if_instr,
  output logic                   o_misaligned
);

  localparam logic [2:0] c_buf_depth = 3'(BUF_DEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] w_req_pc_next;
  logic            r_misaligned;

  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_outstanding;
  logic [2:0]      w_occupancy;
  logic [1:0]      w_buf_count;
  logic            w_head_valid;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;

  // A request is in flight whenever we are waiting for (or discarding) a response
  assign w_outstanding = (r_state == FETCH_WAIT) || (r_state == FETCH_SQUASH);
  assign w_occupancy   = {1'b0, w_buf_count} + {2'b00, w_outstanding};
  assign w_push_entry  = '{pc: r_req_pc, instr: i_imem_rdata};
  assign w_pop         = w_head_valid && !i_stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, PC update and handshake outputs; a redirect overrides everything
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_req_pc_next = r_req_pc;
    w_req         = 1'b0;
    w_push        = 1'b0;

    case (r_state)
      FETCH_IDLE: begin
        w_state_next = FETCH_REQ;
      end
      FETCH_REQ: begin
        // Only ask for what the buffer is guaranteed to absorb
        w_req = (w_occupancy < c_buf_depth);
        if (w_req && i_imem_gnt) begin
          w_pc_next     = r_pc + PC_STEP;
          w_req_pc_next = r_pc;
          w_state_next  = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (i_imem_rvalid) begin
          w_push       = 1'b1;
          w_state_next = FETCH_REQ;
        end
      end
      FETCH_SQUASH: begin
        if (i_imem_rvalid) begin
          w_state_next = FETCH_REQ;
        end
      end
      default: begin
        w_state_next = FETCH_IDLE;
      end
    endcase

    if (i_branch_flush) begin
      w_push    = 1'b0;
      w_pc_next = align_word(i_branch_pc);
      case (r_state)
        // A response arriving now completes the only outstanding request
        FETCH_WAIT:   w_state_next = i_imem_rvalid ? FETCH_REQ : FETCH_SQUASH;
        FETCH_REQ:    w_state_next = (w_req && i_imem_gnt) ? FETCH_SQUASH : FETCH_REQ;
        FETCH_SQUASH: w_state_next = i_imem_rvalid ? FETCH_REQ : FETCH_SQUASH;
        default:      w_state_next = FETCH_REQ;
      endcase
    end
  end

  // Fetch PC, PC of the in-flight request and the misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_req_pc     <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_req_pc     <= w_req_pc_next;
      r_misaligned <= i_branch_flush && (i_branch_pc[1:0] != 2'b00);
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (i_branch_flush),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_count      (w_buf_count),
    .o_head_valid (w_head_valid),
    .o_head       (w_head)
  );

  assign o_imem_req   = w_req;
  assign o_imem_addr  = r_pc;
  assign o_if_valid   = w_head_valid;
  assign o_if_pc      = w_head.pc;
  assign o_if_instr   = w_head.instr;
  assign o_misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_unit
// Brief    : Randomized self-checking bench for fetch_redirect_unit with a
//            transaction-level reference model and a responding memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_branch_flush = 1'b0;
  logic [31:0] i_branch_pc = '0;
  logic        i_stall = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        o_misaligned;

  fetch_redirect_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_branch_flush (i_branch_flush),
    .i_branch_pc    (i_branch_pc),
    .i_stall        (i_stall),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_gnt     (i_imem_gnt),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .o_if_valid     (o_if_valid),
    .o_if_pc        (o_if_pc),
    .o_if_instr     (o_if_instr),
    .o_misaligned   (o_misaligned)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected decode stream and the memory's view of the bus
  logic [63:0] q_exp[$];
  logic [31:0] exp_pc;
  logic [31:0] mem_addr;
  bit          mem_busy;
  bit          mem_squashed;
  bit          first_cycle;
  bit          exp_mis;
  bit          did_mid_reset;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0202;
      2:       return 32'h0000_0040;
      3:       return 32'h0000_0080;
      4:       return 32'hFFFF_FFFC;
      5:       return 32'hFFFF_FFF7;
      default: return $urandom();
    endcase
  endfunction

  task automatic check_reset_outputs(input string where);
    check_eq({where, "_req"},   o_imem_req,   32'd0);
    check_eq({where, "_addr"},  o_imem_addr,  RST_PC);
    check_eq({where, "_valid"}, o_if_valid,   32'd0);
    check_eq({where, "_pc"},    o_if_pc,      32'd0);
    check_eq({where, "_instr"}, o_if_instr,   32'd0);
    check_eq({where, "_mis"},   o_misaligned, 32'd0);
  endtask

  // Hold reset for a few cycles, then release it just after a rising edge
  task automatic do_reset();
    rst_n          = 1'b0;
    i_branch_flush = 1'b0;
    i_branch_pc    = '0;
    i_stall        = 1'b0;
    i_imem_gnt     = 1'b0;
    i_imem_rvalid  = 1'b0;
    i_imem_rdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    q_exp.delete();
    exp_pc       = RST_PC;
    mem_busy     = 1'b0;
    mem_squashed = 1'b0;
    first_cycle  = 1'b1;
    exp_mis      = 1'b0;
    rst_n        = 1'b1;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model
  task automatic step(input int cyc);
    bit          exp_req;
    bit          grant;
    bit          flush;
    logic [31:0] tgt;
    logic [63:0] head;

    exp_req = !first_cycle && !mem_busy && (q_exp.size() < 2);
    check_eq("imem_req", {31'd0, o_imem_req}, {31'd0, exp_req});
    if (exp_req) check_eq("imem_addr", o_imem_addr, exp_pc);
    check_eq("if_valid", {31'd0, o_if_valid}, {31'd0, (q_exp.size() != 0)});
    if (q_exp.size() != 0) begin
      head = q_exp[0];
      check_eq("if_pc",    o_if_pc,    head[63:32]);
      check_eq("if_instr", o_if_instr, head[31:0]);
    end
    check_eq("misaligned", {31'd0, o_misaligned}, {31'd0, exp_mis});

    i_stall       = (cyc < 12) ? 1'b1 : ($urandom_range(0, 2) == 0);
    i_imem_gnt    = (cyc < 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
    i_imem_rvalid = mem_busy && ((cyc < 40) || ($urandom_range(0, 3) != 0));
    i_imem_rdata  = i_imem_rvalid ? mem_data(mem_addr) : $urandom();
    flush         = (cyc >= 20) && ($urandom_range(0, 9) == 0);
    tgt           = pick_target();
    i_branch_flush = flush;
    i_branch_pc    = tgt;

    grant = exp_req && i_imem_gnt;
    if (!flush && (q_exp.size() != 0) && !i_stall) void'(q_exp.pop_front());
    if (i_imem_rvalid) begin
      if (!flush && !mem_squashed) q_exp.push_back({mem_addr, mem_data(mem_addr)});
      mem_busy     = 1'b0;
      mem_squashed = 1'b0;
    end
    if (grant) begin
      mem_busy = 1'b1;
      mem_addr = exp_pc;
      if (!flush) exp_pc = exp_pc + 32'd4;
    end
    if (flush) begin
      q_exp.delete();
      exp_pc = {tgt[31:2], 2'b00};
      if (mem_busy) mem_squashed = 1'b1;
    end
    exp_mis     = flush && (tgt[1:0] != 2'b00);
    first_cycle = 1'b0;

    @(posedge clk);
    #1;
  endtask

  initial begin
    did_mid_reset = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((c >= 1500) && !did_mid_reset && mem_busy && !mem_squashed) begin
        // Asynchronous reset while a response is pending
        did_mid_reset = 1'b1;
        i_imem_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        do_reset();
      end
      step(c);
    end
    if (!did_mid_reset) check_eq("mid_reset_reached", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
